// File: rtl/antitheft_ctrl_gen.sv
// ---------------------------------------------------------------------------
// antitheft_ctrl_gen
// Vehicle anti-theft controller: alarm FSM, four programmable time slots,
// a one-second tick prescaler and a seconds countdown timer.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   ignition     debounced ignition switch
//   doors        debounced door-open flags, bit 0 = driver door
//   reprogram    level; writes param_value into slot param_sel
//   param_sel    00 T_ARM, 01 T_DRV, 10 T_PASS, 11 T_ALARM
//   param_value  value to program (0 is stored as 1)
//   state        current FSM state code
//   status       status LED (blinks while ARMED)
//   siren_en     siren enable (ALARM / HOLD)
//   countdown    remaining seconds of the running timer
//   expired      one-cycle timer expiry pulse
//   tick         one-cycle pulse once per second
// ---------------------------------------------------------------------------
module antitheft_ctrl_gen #(
    parameter int CLK_FREQ    = 100000000,
    parameter int N_DOORS     = 4,
    parameter int TW          = 4,
    parameter int T_ARM_DEF   = 6,
    parameter int T_DRV_DEF   = 8,
    parameter int T_PASS_DEF  = 15,
    parameter int T_ALARM_DEF = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ignition,
    input  logic [N_DOORS-1:0] doors,
    input  logic               reprogram,
    input  logic [1:0]         param_sel,
    input  logic [TW-1:0]      param_value,
    output logic [2:0]         state,
    output logic               status,
    output logic               siren_en,
    output logic [TW-1:0]      countdown,
    output logic               expired,
    output logic               tick
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [1:0] SEL_ARM   = 2'd0;
    localparam logic [1:0] SEL_DRV   = 2'd1;
    localparam logic [1:0] SEL_PASS  = 2'd2;
    localparam logic [1:0] SEL_ALARM = 2'd3;

    typedef enum logic [2:0] {
        ARMED     = 3'd0,
        TRIGGERED = 3'd1,
        ALARM     = 3'd2,
        HOLD      = 3'd3,
        DIS_IGN   = 3'd4,
        DIS_IDLE  = 3'd5,
        DIS_DOOR  = 3'd6,
        ARM_DLY   = 3'd7
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   presc_reg;
    logic            running_reg;
    logic [TW-1:0]   params_reg [4];
    logic            wrap;
    logic            any_door;
    logic            load;
    logic [1:0]      load_sel;
    logic            stop;

    // Prescaler is about to wrap on this edge; this is the internal tick
    // that both the countdown and the status blink act upon.
    assign wrap     = (presc_reg == PW'(CLK_FREQ - 1));
    assign any_door = |doors;
    assign state    = state_reg;

    // Next-state logic with the timer load/stop requests it implies.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_sel   = SEL_ARM;
        stop       = 1'b0;
        if (reprogram) begin
            state_next = ARMED;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (any_door) begin
                        state_next = TRIGGERED;
                        load       = 1'b1;
                        load_sel   = doors[0] ? SEL_DRV : SEL_PASS;
                    end
                end
                TRIGGERED: begin
                    if (ignition)     state_next = DIS_IGN;
                    else if (expired) state_next = ALARM;
                end
                ALARM: begin
                    if (ignition) begin
                        state_next = DIS_IGN;
                    end else if (!any_door) begin
                        state_next = HOLD;
                        load       = 1'b1;
                        load_sel   = SEL_ALARM;
                    end
                end
                HOLD: begin
                    if (ignition) begin
                        state_next = DIS_IGN;
                    end else if (any_door) begin
                        state_next = ALARM;
                        stop       = 1'b1;
                    end else if (expired) begin
                        state_next = ARMED;
                    end
                end
                DIS_IGN: begin
                    if (!ignition) state_next = DIS_IDLE;
                end
                DIS_IDLE: begin
                    if (ignition)      state_next = DIS_IGN;
                    else if (doors[0]) state_next = DIS_DOOR;
                end
                DIS_DOOR: begin
                    if (ignition) begin
                        state_next = DIS_IGN;
                    end else if (!any_door) begin
                        state_next = ARM_DLY;
                        load       = 1'b1;
                        load_sel   = SEL_ARM;
                    end
                end
                default: begin // ARM_DLY
                    if (ignition)     state_next = DIS_IGN;
                    else if (any_door) state_next = DIS_DOOR;
                    else if (expired) state_next = ARMED;
                end
            endcase
            // The disarmed states never run the timer.
            if (state_next == DIS_IGN || state_next == DIS_IDLE || state_next == DIS_DOOR)
                stop = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ARMED;
            presc_reg     <= '0;
            running_reg   <= 1'b0;
            countdown     <= '0;
            expired       <= 1'b0;
            tick          <= 1'b0;
            status        <= 1'b0;
            siren_en      <= 1'b0;
            params_reg[0] <= TW'(T_ARM_DEF);
            params_reg[1] <= TW'(T_DRV_DEF);
            params_reg[2] <= TW'(T_PASS_DEF);
            params_reg[3] <= TW'(T_ALARM_DEF);
        end else begin
            state_reg <= state_next;

            if (reprogram)
                params_reg[param_sel] <= (param_value == '0) ? TW'(1) : param_value;

            // A load realigns the second boundary so expiry lands exactly
            // V*CLK_FREQ cycles after the load.
            if (load || wrap) presc_reg <= '0;
            else              presc_reg <= presc_reg + PW'(1);
            tick <= wrap;

            // Stop freezes the countdown value; a stop on a tick edge
            // suppresses that decrement.
            expired <= 1'b0;
            if (reprogram) begin
                running_reg <= 1'b0;
                countdown   <= '0;
            end else if (load) begin
                running_reg <= 1'b1;
                countdown   <= params_reg[load_sel];
            end else if (stop) begin
                running_reg <= 1'b0;
            end else if (running_reg && wrap) begin
                countdown <= countdown - TW'(1);
                if (countdown == TW'(1)) begin
                    running_reg <= 1'b0;
                    expired     <= 1'b1;
                end
            end

            // Blink restarts dark on every entry into ARMED.
            if (state_next == ARMED)
                status <= (state_reg == ARMED && !reprogram) ? (status ^ wrap) : 1'b0;
            else
                status <= (state_next == TRIGGERED) || (state_next == ALARM) || (state_next == HOLD);

            siren_en <= (state_next == ALARM) || (state_next == HOLD);
        end
    end

endmodule

// File: tb/tb_antitheft_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_antitheft_ctrl_gen
// Bench for antitheft_ctrl_gen with CLK_FREQ=10. A behavioural model tracks
// time as absolute edge numbers (load edge + seconds, prescaler base edge)
// and predicts every output each cycle; a vector table replays the scenario
// walk-through against hand-derived constants; a random phase follows.
// ---------------------------------------------------------------------------
module tb_antitheft_ctrl_gen;

    localparam int CF = 10;
    localparam int ND = 4;
    localparam int TW = 4;

    localparam int S_ARMED = 0, S_TRIG = 1, S_ALARM = 2, S_HOLD = 3;
    localparam int S_DIGN = 4, S_DIDLE = 5, S_DDOOR = 6, S_ARMDLY = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ignition = 1'b0;
    logic [ND-1:0] doors = '0;
    logic          reprogram = 1'b0;
    logic [1:0]    param_sel = '0;
    logic [TW-1:0] param_value = '0;
    logic [2:0]    state;
    logic          status;
    logic          siren_en;
    logic [TW-1:0] countdown;
    logic          expired;
    logic          tick;

    int errors = 0;
    int checks = 0;

    antitheft_ctrl_gen #(.CLK_FREQ(CF), .N_DOORS(ND), .TW(TW)) dut (
        .clock(clock), .reset(reset), .ignition(ignition), .doors(doors),
        .reprogram(reprogram), .param_sel(param_sel), .param_value(param_value),
        .state(state), .status(status), .siren_en(siren_en),
        .countdown(countdown), .expired(expired), .tick(tick)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int m_e;          // edges since reset release
    int m_state;
    int m_par [4];
    int m_base;       // edge at which the 1 s grid was last realigned
    int m_load_edge;
    int m_load_val;
    int m_frozen;     // countdown shown while the timer is not running
    bit m_run, m_exp, m_tick, m_blink;

    function automatic int m_cd_at(int e);
        return m_run ? (m_load_val - (e - m_load_edge) / CF) : m_frozen;
    endfunction

    task automatic model_reset();
        m_e = 0; m_state = S_ARMED;
        m_par[0] = 6; m_par[1] = 8; m_par[2] = 15; m_par[3] = 10;
        m_base = 0; m_load_edge = 0; m_load_val = 0; m_frozen = 0;
        m_run = 0; m_exp = 0; m_tick = 0; m_blink = 0;
    endtask

    task automatic model_step();
        int nxt, lv;
        bit ld, stp, any, tk;
        m_e++;
        any = (doors != '0);
        tk  = ((m_e - m_base) % CF) == 0;
        nxt = m_state; ld = 0; stp = 0; lv = 0;
        if (reprogram) begin
            m_par[param_sel] = (param_value == '0) ? 1 : int'(param_value);
            nxt = S_ARMED;
        end else begin
            case (m_state)
                S_ARMED:  if (any) begin nxt = S_TRIG; ld = 1; lv = doors[0] ? m_par[1] : m_par[2]; end
                S_TRIG:   if (ignition) nxt = S_DIGN; else if (m_exp) nxt = S_ALARM;
                S_ALARM:  if (ignition) nxt = S_DIGN;
                          else if (!any) begin nxt = S_HOLD; ld = 1; lv = m_par[3]; end
                S_HOLD:   if (ignition) nxt = S_DIGN; else if (any) begin nxt = S_ALARM; stp = 1; end
                          else if (m_exp) nxt = S_ARMED;
                S_DIGN:   if (!ignition) nxt = S_DIDLE;
                S_DIDLE:  if (ignition) nxt = S_DIGN; else if (doors[0]) nxt = S_DDOOR;
                S_DDOOR:  if (ignition) nxt = S_DIGN;
                          else if (!any) begin nxt = S_ARMDLY; ld = 1; lv = m_par[0]; end
                default:  if (ignition) nxt = S_DIGN; else if (any) nxt = S_DDOOR;
                          else if (m_exp) nxt = S_ARMED;
            endcase
            if (nxt == S_DIGN || nxt == S_DIDLE || nxt == S_DDOOR) stp = 1;
        end
        m_exp = 0;
        if (reprogram) begin
            m_run = 0; m_frozen = 0;
        end else if (ld) begin
            m_run = 1; m_load_edge = m_e; m_load_val = lv;
        end else if (stp) begin
            m_frozen = m_cd_at(m_e - 1); m_run = 0;
        end else if (m_run && m_e == m_load_edge + m_load_val * CF) begin
            m_run = 0; m_frozen = 0; m_exp = 1;
        end
        if (nxt == S_ARMED)
            m_blink = (m_state == S_ARMED && !reprogram) ? (m_blink ^ tk) : 1'b0;
        if (ld) m_base = m_e;
        m_tick  = tk;
        m_state = nxt;
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, m_e, act, want);
        end
    endtask

    task automatic check_model();
        int want_status;
        if (m_state == S_ARMED) want_status = int'(m_blink);
        else want_status = (m_state == S_TRIG || m_state == S_ALARM || m_state == S_HOLD) ? 1 : 0;
        chk("m_state",     int'(state),     m_state);
        chk("m_status",    int'(status),    want_status);
        chk("m_siren",     int'(siren_en),  (m_state == S_ALARM || m_state == S_HOLD) ? 1 : 0);
        chk("m_countdown", int'(countdown), m_cd_at(m_e));
        chk("m_expired",   int'(expired),   int'(m_exp));
        chk("m_tick",      int'(tick),      int'(m_tick));
    endtask

    // Inputs are set right after a negedge; model predicts the next posedge.
    task automatic cycle();
        model_step();
        @(negedge clock);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        ignition = 1'b0; doors = '0; reprogram = 1'b0; param_sel = '0; param_value = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       ign;
        logic [3:0] drs;
        logic       rp;
        logic [1:0] sel;
        logic [3:0] val;
        int         n;
        bit         chk_cd;
        int         st, cd, siren, stat, expd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic ig, logic [3:0] d, logic r, logic [1:0] s,
                                logic [3:0] v, int n, bit c, int st, int cd, int sr,
                                int sta, int ex);
        vec_t x;
        x.name = nm; x.ign = ig; x.drs = d; x.rp = r; x.sel = s; x.val = v; x.n = n;
        x.chk_cd = c; x.st = st; x.cd = cd; x.siren = sr; x.stat = sta; x.expd = ex;
        return x;
    endfunction

    initial begin
        //                   name          ign doors    rp sel val  n  cd? st cd sr sta ex
        vecs.push_back(mk("drv_open",    0, 4'b0001, 0, 0, 0,  1, 1, 1, 8, 0, 1, 0));
        vecs.push_back(mk("drv_wait",    0, 4'b0001, 0, 0, 0, 79, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk("drv_exp",     0, 4'b0001, 0, 0, 0,  1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("alarm",       0, 4'b0001, 0, 0, 0,  1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk("hold",        0, 4'b0000, 0, 0, 0,  1, 1, 3,10, 1, 1, 0));
        vecs.push_back(mk("hold_run",    0, 4'b0000, 0, 0, 0, 49, 1, 3, 6, 1, 1, 0));
        vecs.push_back(mk("reopen",      0, 4'b0100, 0, 0, 0,  1, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk("reclose",     0, 4'b0000, 0, 0, 0,  1, 1, 3,10, 1, 1, 0));
        vecs.push_back(mk("hold_run2",   0, 4'b0000, 0, 0, 0, 99, 1, 3, 1, 1, 1, 0));
        vecs.push_back(mk("hold_exp",    0, 4'b0000, 0, 0, 0,  1, 1, 3, 0, 1, 1, 1));
        vecs.push_back(mk("rearm",       0, 4'b0000, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("blink_on",    0, 4'b0000, 0, 0, 0,  9, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("blink_off",   0, 4'b0000, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pass_open",   0, 4'b0110, 0, 0, 0,  1, 1, 1,15, 0, 1, 0));
        vecs.push_back(mk("pass_wait",   0, 4'b0000, 0, 0, 0, 29, 1, 1,13, 0, 1, 0));
        vecs.push_back(mk("ign_on",      1, 4'b0000, 0, 0, 0,  1, 0, 4, 0, 0, 0, 0));
        vecs.push_back(mk("ign_hold",    1, 4'b0000, 0, 0, 0, 20, 0, 4, 0, 0, 0, 0));
        vecs.push_back(mk("ign_off",     0, 4'b0000, 0, 0, 0,  1, 0, 5, 0, 0, 0, 0));
        vecs.push_back(mk("drv_disarm",  0, 4'b0001, 0, 0, 0,  1, 0, 6, 0, 0, 0, 0));
        vecs.push_back(mk("arm_dly",     0, 4'b0000, 0, 0, 0,  1, 1, 7, 6, 0, 0, 0));
        vecs.push_back(mk("arm_run",     0, 4'b0000, 0, 0, 0, 39, 1, 7, 3, 0, 0, 0));
        vecs.push_back(mk("arm_reopen",  0, 4'b1000, 0, 0, 0,  1, 0, 6, 0, 0, 0, 0));
        vecs.push_back(mk("arm_dly2",    0, 4'b0000, 0, 0, 0,  1, 1, 7, 6, 0, 0, 0));
        vecs.push_back(mk("arm_run2",    0, 4'b0000, 0, 0, 0, 59, 1, 7, 1, 0, 0, 0));
        vecs.push_back(mk("arm_exp",     0, 4'b0000, 0, 0, 0,  1, 1, 7, 0, 0, 0, 1));
        vecs.push_back(mk("armed2",      0, 4'b0000, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("blink_on2",   0, 4'b0000, 0, 0, 0,  9, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("blink_off2",  0, 4'b0000, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("trig",        0, 4'b0001, 0, 0, 0,  1, 1, 1, 8, 0, 1, 0));
        vecs.push_back(mk("alarm2",      0, 4'b0001, 0, 0, 0, 81, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk("reprog_drv",  0, 4'b0001, 1, 1, 3,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("trig3",       0, 4'b0001, 0, 0, 0,  1, 1, 1, 3, 0, 1, 0));
        vecs.push_back(mk("trig3_wait",  0, 4'b0000, 0, 0, 0, 29, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk("trig3_exp",   0, 4'b0000, 0, 0, 0,  1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("alarm3",      0, 4'b0000, 0, 0, 0,  1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk("reprog_pass", 0, 4'b0000, 1, 2, 0,  1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("pass1",       0, 4'b0010, 0, 0, 0,  1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk("pass1_wait",  0, 4'b0000, 0, 0, 0,  9, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk("pass1_exp",   0, 4'b0000, 0, 0, 0,  1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("alarm4",      0, 4'b0000, 0, 0, 0,  1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk("hold4",       0, 4'b0000, 0, 0, 0,  5, 1, 3,10, 1, 1, 0));

        do_reset();

        foreach (vecs[i]) begin
            ignition = vecs[i].ign; doors = vecs[i].drs; reprogram = vecs[i].rp;
            param_sel = vecs[i].sel; param_value = vecs[i].val;
            for (int k = 0; k < vecs[i].n; k++) cycle();
            chk({"v_state_", vecs[i].name}, int'(state), vecs[i].st);
            if (vecs[i].chk_cd) chk({"v_countdown_", vecs[i].name}, int'(countdown), vecs[i].cd);
            chk({"v_siren_", vecs[i].name},   int'(siren_en), vecs[i].siren);
            chk({"v_status_", vecs[i].name},  int'(status),   vecs[i].stat);
            chk({"v_expired_", vecs[i].name}, int'(expired),  vecs[i].expd);
            $display("vec %0d %s: state=%0d countdown=%0d siren=%0d status=%0d",
                     i, vecs[i].name, state, countdown, siren_en, status);
        end
        reprogram = 1'b0;

        // Asynchronous reset in the middle of a HOLD countdown.
        #2 reset = 1'b1;
        #1;
        chk("areset_state",     int'(state),     S_ARMED);
        chk("areset_status",    int'(status),    0);
        chk("areset_siren",     int'(siren_en),  0);
        chk("areset_countdown", int'(countdown), 0);
        chk("areset_expired",   int'(expired),   0);
        chk("areset_tick",      int'(tick),      0);
        $display("async reset: state=%0d countdown=%0d", state, countdown);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_model();
        doors = 4'b0010;
        cycle();
        chk("tpass_restored", int'(countdown), 15);
        chk("tpass_state",    int'(state),     S_TRIG);
        $display("after reset: passenger door countdown=%0d", countdown);

        // Random phase against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 24) == 0)
                doors = ($urandom_range(0, 1) == 1) ? ND'($urandom) : '0;
            if ($urandom_range(0, 59) == 0) ignition = ~ignition;
            reprogram   = ($urandom_range(0, 199) == 0);
            param_sel   = 2'($urandom_range(0, 3));
            param_value = TW'($urandom_range(0, 5));
            if (reprogram)
                $display("random reprogram: edge=%0d sel=%0d value=%0d", m_e + 1, param_sel, param_value);
            cycle();
        end
        reprogram = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/antitheft_ctrl_gen.md
Name: antitheft_ctrl_gen

Overview:
- Parametrised anti-theft controller: alarm FSM, four programmable time parameters, one-second tick generator and countdown timer in one block.
- Generalises the fixed two-door alarm to N_DOORS doors (door 0 = driver, rest = passenger) and configurable timer width and tick rate.
- Adds an explicit alarm-hold phase and an arming delay.
- Sits between the debounced inputs and the siren generator / display driver in the vehicle top level.

Parameters:
- CLK_FREQ, 100000000, clock cycles per tick (one tick = 1 s); benches use 10.
- N_DOORS, 4, number of door inputs, minimum 2.
- TW, 4, width of time parameters and countdown.
- T_ARM_DEF, 6, default arming delay in seconds.
- T_DRV_DEF, 8, default driver-door entry delay.
- T_PASS_DEF, 15, default passenger-door entry delay.
- T_ALARM_DEF, 10, default alarm hold time.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ignition  in  1  debounced ignition switch.
- doors  in  N_DOORS  debounced door-open flags; bit 0 is the driver door.
- reprogram  in  1  level; write param_value into the slot selected by param_sel.
- param_sel  in  2  slot select: 00 T_ARM, 01 T_DRV, 10 T_PASS, 11 T_ALARM.
- param_value  in  TW  value to program.
- state  out  3  current FSM state code.
- status  out  1  status LED.
- siren_en  out  1  siren enable.
- countdown  out  TW  remaining seconds.
- expired  out  1  one-cycle timer expiry pulse.
- tick  out  1  one-cycle 1 Hz pulse.

Behaviour:
- Reset (async): state=ARMED(0), parameters=defaults, countdown=0, timer idle, tick prescaler=0. Outputs status, siren_en, expired and tick are all 0.
- Tick generator: free-running prescaler 0..CLK_FREQ-1. tick=1 for the single cycle the prescaler wraps. The prescaler clears to 0 on every timer load.
- Timer:
  - A load sets countdown=V and runs the timer.
  - Each tick decrements countdown. On the tick where countdown goes 1->0, expired pulses for exactly one cycle and the timer goes idle.
  - expired is registered and occurs exactly V*CLK_FREQ cycles after the load cycle.
  - Idle timer ignores ticks. A new load while running restarts the count.
- Parameter write: param_value=0 is stored as 1, so no zero-length timeouts exist. Writes take effect on the next load.
- Priority in every cycle: reprogram > ignition-disarm > doors > expired.
- reprogram=1: write the selected slot, force state=ARMED, stop the timer, countdown=0.
- States and transitions ("any door" = |doors, "all closed" = doors==0):
  - ARMED(0): any door open -> TRIGGERED. Load T_DRV if doors[0] is set, else T_PASS; driver wins when several doors open together. Ignition is ignored in this state.
  - TRIGGERED(1): ignition -> DIS_IGN. Otherwise expired -> ALARM.
  - ALARM(2): ignition -> DIS_IGN. Otherwise all closed -> HOLD, load T_ALARM.
  - HOLD(3): ignition -> DIS_IGN. Otherwise any door open -> ALARM (timer stopped). Otherwise expired -> ARMED.
  - DIS_IGN(4): ignition low -> DIS_IDLE.
  - DIS_IDLE(5): ignition -> DIS_IGN. Otherwise doors[0] -> DIS_DOOR.
  - DIS_DOOR(6): ignition -> DIS_IGN. Otherwise all closed -> ARM_DLY, load T_ARM.
  - ARM_DLY(7): ignition -> DIS_IGN. Otherwise any door open -> DIS_DOOR (timer stopped). Otherwise expired -> ARMED.
- Entering any DIS_* state stops the timer.
- status:
  - ARMED: toggles on every tick (0.5 Hz blink) and is 0 on entry to ARMED.
  - TRIGGERED, ALARM, HOLD: 1.
  - All other states: 0.
- siren_en = 1 in ALARM and HOLD only.
- All outputs are registered; a state change is visible one cycle after the causing input.
- Countdown arithmetic is unsigned TW bits, never wraps below 0. Maximum programmable value is 2^TW-1.

Test Plan:
- Reset, CLK_FREQ=10, defaults: open doors[0] -> TRIGGERED, countdown=8. No ignition -> expired at 80 cycles after load, state=ALARM, siren_en=1.
- doors=4'b0110 in ARMED -> countdown=15. Ignition at 30 cycles -> DIS_IGN, siren_en=0, status=0, timer stopped.
- In ALARM, close all doors -> HOLD, countdown=10. Reopen door 2 at 50 cycles -> ALARM. Close again -> HOLD with countdown=10 restarted. Expiry after 100 cycles -> ARMED.
- Disarm sequence ignition on, then off, then doors[0] open, then closed -> ARM_DLY with countdown=6. Reopen at 40 cycles -> DIS_DOOR. Close, wait 60 cycles -> ARMED, status toggles every 10 cycles.
- reprogram with param_sel=01, param_value=3 during ALARM -> state=ARMED, siren_en=0. Then open doors[0] -> countdown=3, expired 30 cycles after load.
- param_value=0 programmed to T_PASS, then doors[1] opens -> countdown=1, expired 10 cycles later. Assert reset mid-count -> all outputs 0, state=ARMED, T_PASS back to 15.
